// File: rtl/id_decode_stage.sv
// Decode stage: latches {pc,inst} from fetch and decodes MIPS integer ALU ops into one-hot aluop, operands and writeback info.
// Latency: a bundle accepted at edge N is presented on ds_* in cycle N+1; the outputs are combinational from the stage register and rf_rdata*.
// Backpressure: holds its bundle while a RAW hazard is pending or es_allowin=0 (ds_allowin=0 then); flush drops the held bundle.
//
// Ports:
//   clk, resetn (sync, active low), flush
//   fs_to_ds_valid / fs_to_ds_bus {pc,inst} / ds_allowin   : fetch side handshake
//   rf_raddr1/rf_rdata1 (rs), rf_raddr2/rf_rdata2 (rt)      : register file read ports
//   es_wdest, ms_wdest, ws_wdest {valid,dest}               : in-flight writers, used for RAW stall
//   es_allowin / ds_to_es_valid                             : execute side handshake
//   ds_aluop, ds_scr0, ds_scr1, ds_ov_en, ds_rf_we, ds_rf_dest, ds_pc, ds_ri : decoded bundle
module id_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        fs_to_ds_valid,
    input  logic [63:0] fs_to_ds_bus,
    output logic        ds_allowin,
    output logic [4:0]  rf_raddr1,
    input  logic [31:0] rf_rdata1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata2,
    input  logic [5:0]  es_wdest,
    input  logic [5:0]  ms_wdest,
    input  logic [5:0]  ws_wdest,
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [11:0] ds_aluop,
    output logic [31:0] ds_scr0,
    output logic [31:0] ds_scr1,
    output logic        ds_ov_en,
    output logic        ds_rf_we,
    output logic [4:0]  ds_rf_dest,
    output logic [31:0] ds_pc,
    output logic        ds_ri
);

    logic        ds_valid;
    logic [31:0] ds_inst;
    logic        ds_ready_go;

    // Stage register. Flush beats a concurrent fetch so a redirected
    // instruction never slips in behind the discarded one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
            ds_inst  <= '0;
            ds_pc    <= RESET_PC;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else begin
            if (ds_allowin) begin
                ds_valid <= fs_to_ds_valid;
            end
            if (ds_allowin && fs_to_ds_valid) begin
                ds_pc   <= fs_to_ds_bus[63:32];
                ds_inst <= fs_to_ds_bus[31:0];
            end
        end
    end

    // Instruction fields
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;

    assign op    = ds_inst[31:26];
    assign rs    = ds_inst[25:21];
    assign rt    = ds_inst[20:16];
    assign rd    = ds_inst[15:11];
    assign sa    = ds_inst[10:6];
    assign imm   = ds_inst[15:0];
    assign funct = ds_inst[5:0];

    logic is_r;
    assign is_r = (op == 6'h00);

    // R-type decodes
    logic f_add, f_addu, f_sub, f_subu, f_and, f_or, f_xor, f_nor;
    logic f_slt, f_sltu, f_sll, f_srl, f_sra, f_sllv, f_srlv, f_srav;
    assign f_add  = is_r && (funct == 6'h20);
    assign f_addu = is_r && (funct == 6'h21);
    assign f_sub  = is_r && (funct == 6'h22);
    assign f_subu = is_r && (funct == 6'h23);
    assign f_and  = is_r && (funct == 6'h24);
    assign f_or   = is_r && (funct == 6'h25);
    assign f_xor  = is_r && (funct == 6'h26);
    assign f_nor  = is_r && (funct == 6'h27);
    assign f_slt  = is_r && (funct == 6'h2A);
    assign f_sltu = is_r && (funct == 6'h2B);
    assign f_sll  = is_r && (funct == 6'h00);
    assign f_srl  = is_r && (funct == 6'h02);
    assign f_sra  = is_r && (funct == 6'h03);
    assign f_sllv = is_r && (funct == 6'h04);
    assign f_srlv = is_r && (funct == 6'h06);
    assign f_srav = is_r && (funct == 6'h07);

    // I-type decodes
    logic i_addi, i_addiu, i_slti, i_sltiu, i_andi, i_ori, i_xori, i_lui;
    assign i_addi  = (op == 6'h08);
    assign i_addiu = (op == 6'h09);
    assign i_slti  = (op == 6'h0A);
    assign i_sltiu = (op == 6'h0B);
    assign i_andi  = (op == 6'h0C);
    assign i_ori   = (op == 6'h0D);
    assign i_xori  = (op == 6'h0E);
    assign i_lui   = (op == 6'h0F);

    assign ds_aluop = {
        f_add | f_addu | i_addi | i_addiu,  // add
        f_sub | f_subu,                     // sub
        f_and | i_andi,                     // and
        f_or  | i_ori,                      // or
        f_nor,                              // nor
        f_xor | i_xori,                     // xor
        f_slt | i_slti,                     // slt
        f_sltu | i_sltiu,                   // sltu
        f_sll | f_sllv,                     // sll
        f_srl | f_srlv,                     // srl
        f_sra | f_srav,                     // sra
        i_lui                               // lui
    };

    // Every recognised encoding sets exactly one aluop bit.
    assign ds_ri = ~|ds_aluop;

    logic shift_imm;
    logic r_alu;
    logic i_alu;
    logic imm_sext;
    logic imm_zext;
    logic rs_used;
    logic rt_used;

    assign shift_imm = f_sll | f_srl | f_sra;
    assign r_alu     = is_r && !ds_ri;
    assign i_alu     = !is_r && !ds_ri;
    // SLTIU sign-extends too; the unsigned compare happens in the ALU.
    assign imm_sext  = i_addi | i_addiu | i_slti | i_sltiu;
    assign imm_zext  = i_andi | i_ori | i_xori | i_lui;
    assign rs_used   = (r_alu && !shift_imm) || (i_alu && !i_lui);
    assign rt_used   = r_alu;

    assign rf_raddr1  = rs;
    assign rf_raddr2  = rt;
    assign ds_scr0    = shift_imm ? {27'b0, sa} : rf_rdata1;
    assign ds_scr1    = imm_sext ? {{16{imm[15]}}, imm} :
                        imm_zext ? {16'b0, imm} : rf_rdata2;
    assign ds_ov_en   = f_add | f_sub | i_addi;
    assign ds_rf_we   = !ds_ri;
    assign ds_rf_dest = is_r ? rd : rt;

    // RAW hazard: no forwarding, so any in-flight writer of a used source
    // stalls. GPR0 is hard-wired, never a real dependency.
    function automatic logic dest_hit(input logic [4:0] src, input logic [5:0] wdest);
        return wdest[5] && (wdest[4:0] == src);
    endfunction

    logic rs_hazard;
    logic rt_hazard;
    assign rs_hazard = rs_used && (rs != 5'd0) &&
                       (dest_hit(rs, es_wdest) || dest_hit(rs, ms_wdest) || dest_hit(rs, ws_wdest));
    assign rt_hazard = rt_used && (rt != 5'd0) &&
                       (dest_hit(rt, es_wdest) || dest_hit(rt, ms_wdest) || dest_hit(rt, ws_wdest));

    assign ds_ready_go    = !(rs_hazard || rt_hazard);
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go && !flush;

endmodule

// File: tb/tb_id_decode_stage.sv
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        fs_to_ds_valid = 1'b0;
    logic [63:0] fs_to_ds_bus = '0;
    logic        ds_allowin;
    logic [4:0]  rf_raddr1;
    logic [31:0] rf_rdata1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;
    logic [5:0]  es_wdest = '0;
    logic [5:0]  ms_wdest = '0;
    logic [5:0]  ws_wdest = '0;
    logic        es_allowin = 1'b1;
    logic        ds_to_es_valid;
    logic [11:0] ds_aluop;
    logic [31:0] ds_scr0;
    logic [31:0] ds_scr1;
    logic        ds_ov_en;
    logic        ds_rf_we;
    logic [4:0]  ds_rf_dest;
    logic [31:0] ds_pc;
    logic        ds_ri;

    logic [31:0] rf [32];
    int n_checks = 0;
    int n_fail   = 0;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .ds_allowin(ds_allowin),
        .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1), .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
        .es_wdest(es_wdest), .ms_wdest(ms_wdest), .ws_wdest(ws_wdest), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_aluop(ds_aluop), .ds_scr0(ds_scr0), .ds_scr1(ds_scr1),
        .ds_ov_en(ds_ov_en), .ds_rf_we(ds_rf_we), .ds_rf_dest(ds_rf_dest), .ds_pc(ds_pc), .ds_ri(ds_ri)
    );

    // Reference decode tables: opcode/funct -> ALU unit number
    // (0 add,1 sub,2 and,3 or,4 nor,5 xor,6 slt,7 sltu,8 sll,9 srl,10 sra,11 lui).
    localparam logic [5:0] R_FN   [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    localparam int         R_UNIT [16] = '{0, 0, 1, 1, 2, 3, 5, 4, 6, 7, 8, 9, 10, 8, 9, 10};
    localparam logic [5:0] I_OP   [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    localparam int         I_UNIT [8]  = '{0, 0, 6, 7, 2, 3, 5, 11};

    typedef struct packed {
        logic        ri;
        logic [11:0] aluop;
        logic [31:0] scr0;
        logic        chk_scr0;
        logic [31:0] scr1;
        logic [4:0]  dest;
        logic        we;
        logic        ov;
        logic        rs_used;
        logic        rt_used;
    } exp_t;

    function automatic exp_t ref_decode(input logic [31:0] inst);
        exp_t e;
        int unit;
        logic [5:0] op;
        logic [5:0] fn;
        logic shimm;
        op = inst[31:26];
        fn = inst[5:0];
        unit = -1;
        e = '0;
        if (op == 6'd0) begin
            for (int k = 0; k < 16; k++) if (fn == R_FN[k]) unit = R_UNIT[k];
        end else begin
            for (int k = 0; k < 8; k++) if (op == I_OP[k]) unit = I_UNIT[k];
        end
        if (unit < 0) begin
            e.ri = 1'b1;
            return e;
        end
        e.aluop = 12'h800 >> unit;
        e.we    = 1'b1;
        if (op == 6'd0) begin
            shimm      = (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03);
            e.scr0     = shimm ? 32'(inst[10:6]) : rf[inst[25:21]];
            e.chk_scr0 = 1'b1;
            e.scr1     = rf[inst[20:16]];
            e.dest     = inst[15:11];
            e.ov       = (fn == 6'h20) || (fn == 6'h22);
            e.rs_used  = !shimm;
            e.rt_used  = 1'b1;
        end else begin
            e.scr0     = rf[inst[25:21]];
            e.chk_scr0 = (op != 6'h0F);
            e.scr1     = (op <= 6'h0B) ? {{16{inst[15]}}, inst[15:0]} : {16'h0, inst[15:0]};
            e.dest     = inst[20:16];
            e.ov       = (op == 6'h08);
            e.rs_used  = (op != 6'h0F);
            e.rt_used  = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hands one bundle to the stage; returns 1 time unit after the accepting edge.
    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        int n;
        n = 0;
        es_wdest = '0;
        ms_wdest = '0;
        ws_wdest = '0;
        #1;
        while (!ds_allowin && n < 20) begin
            tick();
            n++;
        end
        if (!ds_allowin) begin
            n_checks++;
            n_fail++;
            $display("FAIL present_timeout inst=%h allowin=%b required=1", inst, ds_allowin);
        end
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {pc, inst};
        tick();
        fs_to_ds_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h1000, 32'h2422FFFF};
        tick();
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ds_to_es_valid); end
        n_checks++; if (ds_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got=%b exp=1", ds_allowin); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_addiu();
        rf[1] = 32'd5;
        present(32'h2422FFFF, 32'hBFC0_0000);
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL addiu_valid got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (ds_aluop !== 12'h800) begin n_fail++; $display("FAIL addiu_aluop got=%h exp=800", ds_aluop); end
        n_checks++; if (ds_scr0 !== 32'd5) begin n_fail++; $display("FAIL addiu_scr0 got=%h exp=5", ds_scr0); end
        n_checks++; if (ds_scr1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addiu_scr1 got=%h exp=ffffffff", ds_scr1); end
        n_checks++; if (ds_rf_dest !== 5'd2) begin n_fail++; $display("FAIL addiu_dest got=%0d exp=2", ds_rf_dest); end
        n_checks++; if (ds_ov_en !== 1'b0) begin n_fail++; $display("FAIL addiu_ov got=%b exp=0", ds_ov_en); end
        n_checks++; if (ds_rf_we !== 1'b1) begin n_fail++; $display("FAIL addiu_we got=%b exp=1", ds_rf_we); end
        n_checks++; if (ds_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL addiu_pc got=%h exp=bfc00000", ds_pc); end
        tick();
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL addiu_drain got=%b exp=0", ds_to_es_valid); end
    endtask

    task automatic test_shift();
        rf[2] = 32'h1;
        present(32'h00021900, 32'h10);
        #1;
        n_checks++; if (ds_aluop !== 12'h008) begin n_fail++; $display("FAIL sll_aluop got=%h exp=008", ds_aluop); end
        n_checks++; if (ds_scr0 !== 32'd4) begin n_fail++; $display("FAIL sll_scr0 got=%h exp=4", ds_scr0); end
        n_checks++; if (ds_scr1 !== 32'd1) begin n_fail++; $display("FAIL sll_scr1 got=%h exp=1", ds_scr1); end
        n_checks++; if (ds_rf_dest !== 5'd3) begin n_fail++; $display("FAIL sll_dest got=%0d exp=3", ds_rf_dest); end
        // SLL with rs field = 5 and $5 pending: rs is not a source, no stall.
        present(32'h00A21900, 32'h14);
        es_wdest = {1'b1, 5'd5};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL sll_rs_ignored got=%b exp=1", ds_to_es_valid); end
        ws_wdest = {1'b1, 5'd2};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL sll_rt_stall got=%b exp=0", ds_to_es_valid); end
        es_wdest = '0;
        ws_wdest = '0;
    endtask

    task automatic test_lui_ori();
        present(32'h3C041234, 32'h20);
        #1;
        n_checks++; if (ds_aluop !== 12'h001) begin n_fail++; $display("FAIL lui_aluop got=%h exp=001", ds_aluop); end
        n_checks++; if (ds_scr1 !== 32'h0000_1234) begin n_fail++; $display("FAIL lui_scr1 got=%h exp=00001234", ds_scr1); end
        n_checks++; if (ds_rf_dest !== 5'd4) begin n_fail++; $display("FAIL lui_dest got=%0d exp=4", ds_rf_dest); end
        present(32'h34058000, 32'h24);
        #1;
        n_checks++; if (ds_aluop !== 12'h100) begin n_fail++; $display("FAIL ori_aluop got=%h exp=100", ds_aluop); end
        n_checks++; if (ds_scr1 !== 32'h0000_8000) begin n_fail++; $display("FAIL ori_scr1 got=%h exp=00008000", ds_scr1); end
        n_checks++; if (ds_rf_dest !== 5'd5) begin n_fail++; $display("FAIL ori_dest got=%0d exp=5", ds_rf_dest); end
    endtask

    task automatic test_hazard();
        rf[2] = 32'h2222;
        rf[3] = 32'h3333;
        present(32'h00432821, 32'h30);
        es_wdest = {1'b1, 5'd2};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL haz_valid got=%b exp=0", ds_to_es_valid); end
        n_checks++; if (ds_allowin !== 1'b0) begin n_fail++; $display("FAIL haz_allowin got=%b exp=0", ds_allowin); end
        tick();
        es_wdest = '0;
        ms_wdest = {1'b1, 5'd3};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL haz_rt_valid got=%b exp=0", ds_to_es_valid); end
        ms_wdest = '0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL haz_release got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (ds_aluop !== 12'h800) begin n_fail++; $display("FAIL haz_aluop got=%h exp=800", ds_aluop); end
        n_checks++; if (ds_scr0 !== 32'h2222 || ds_scr1 !== 32'h3333) begin n_fail++; $display("FAIL haz_operands got=%h,%h exp=2222,3333", ds_scr0, ds_scr1); end
        n_checks++; if (ds_rf_dest !== 5'd5) begin n_fail++; $display("FAIL haz_dest got=%0d exp=5", ds_rf_dest); end
        // rs = $0 with a pending write to $0: no dependency.
        present(32'h00032821, 32'h34);
        es_wdest = {1'b1, 5'd0};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL haz_zero got=%b exp=1", ds_to_es_valid); end
        // I-type rt is the destination, not a source.
        present(32'h2422FFFF, 32'h38);
        ws_wdest = {1'b1, 5'd2};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL haz_itype_rt got=%b exp=1", ds_to_es_valid); end
        ws_wdest = '0;
    endtask

    task automatic test_backpressure();
        int transfers;
        transfers = 0;
        present(32'h00432821, 32'h100);
        es_allowin = 1'b0;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h200, 32'h3C041234};
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (ds_allowin !== 1'b0 || ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold c=%0d allowin=%b valid=%b exp=0,1", c, ds_allowin, ds_to_es_valid); end
            n_checks++; if (ds_pc !== 32'h100 || ds_aluop !== 12'h800) begin n_fail++; $display("FAIL bp_stable c=%0d pc=%h aluop=%h exp=100,800", c, ds_pc, ds_aluop); end
        end
        fs_to_ds_valid = 1'b0;
        es_allowin = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ds_to_es_valid && es_allowin) transfers++;
            tick();
        end
        n_checks++; if (transfers !== 1) begin n_fail++; $display("FAIL bp_transfers got=%0d exp=1", transfers); end
    endtask

    task automatic test_flush();
        present(32'h2422FFFF, 32'h300);
        flush = 1'b1;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h304, 32'h34058000};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL flush_same_cycle got=%b exp=0", ds_to_es_valid); end
        tick();
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_empty valid=%b allowin=%b exp=0,1", ds_to_es_valid, ds_allowin); end
        // Flush while stalled on a hazard.
        present(32'h00432821, 32'h308);
        es_wdest = {1'b1, 5'd2};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        es_wdest = '0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_stalled valid=%b allowin=%b exp=0,1", ds_to_es_valid, ds_allowin); end
    endtask

    task automatic test_ri();
        present(32'hFC000000, 32'h400);
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1 || ds_ri !== 1'b1) begin n_fail++; $display("FAIL ri_op3f valid=%b ri=%b exp=1,1", ds_to_es_valid, ds_ri); end
        n_checks++; if (ds_aluop !== 12'h000 || ds_rf_we !== 1'b0 || ds_ov_en !== 1'b0) begin n_fail++; $display("FAIL ri_op3f_fields aluop=%h we=%b ov=%b exp=000,0,0", ds_aluop, ds_rf_we, ds_ov_en); end
        present(32'h00000001, 32'h404);
        #1;
        n_checks++; if (ds_ri !== 1'b1 || ds_aluop !== 12'h000) begin n_fail++; $display("FAIL ri_funct01 ri=%b aluop=%h exp=1,000", ds_ri, ds_aluop); end
    endtask

    task automatic test_reset_stall();
        present(32'h00432821, 32'h500);
        es_wdest = {1'b1, 5'd2};
        #1;
        n_checks++; if (ds_allowin !== 1'b0) begin n_fail++; $display("FAIL rststall_pre allowin=%b exp=0", ds_allowin); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        es_wdest = '0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1) begin n_fail++; $display("FAIL rststall_post valid=%b allowin=%b exp=0,1", ds_to_es_valid, ds_allowin); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            logic [31:0] inst;
            logic [31:0] pc;
            logic [5:0]  wd [3];
            logic [4:0]  d;
            logic        stall;
            exp_t        e;
            int          sel;
            sel  = $urandom_range(0, 9);
            inst = $urandom;
            pc   = $urandom;
            if (sel <= 4) begin
                inst[31:26] = 6'h00;
                inst[5:0]   = R_FN[$urandom_range(0, 15)];
            end else if (sel <= 7) begin
                inst[31:26] = I_OP[$urandom_range(0, 7)];
                if (inst[31:26] == 6'h0F) inst[25:21] = 5'd0;
            end else if (sel == 9) begin
                inst[31:26] = 6'h00;
            end
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            present(inst, pc);
            e = ref_decode(inst);
            stall = 1'b0;
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 2))
                    0: d = inst[25:21];
                    1: d = inst[20:16];
                    default: d = 5'($urandom);
                endcase
                wd[k] = {1'($urandom), d};
                if (wd[k][5] && ((e.rs_used && inst[25:21] != 0 && wd[k][4:0] == inst[25:21]) ||
                                 (e.rt_used && inst[20:16] != 0 && wd[k][4:0] == inst[20:16])))
                    stall = 1'b1;
            end
            es_wdest = wd[0];
            ms_wdest = wd[1];
            ws_wdest = wd[2];
            #1;
            n_checks++; if (ds_to_es_valid !== !stall || ds_allowin !== !stall) begin n_fail++; $display("FAIL rnd_stall inst=%h wd=%h,%h,%h valid=%b allowin=%b exp_stall=%b", inst, wd[0], wd[1], wd[2], ds_to_es_valid, ds_allowin, stall); end
            if (stall) begin
                tick();
                n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_stall_hold inst=%h valid=%b exp=0", inst, ds_to_es_valid); end
                es_wdest = '0;
                ms_wdest = '0;
                ws_wdest = '0;
                #1;
            end
            n_checks++; if (ds_to_es_valid !== 1'b1 || ds_pc !== pc) begin n_fail++; $display("FAIL rnd_valid_pc inst=%h valid=%b pc=%h exp=1,%h", inst, ds_to_es_valid, ds_pc, pc); end
            n_checks++; if (ds_ri !== e.ri || ds_aluop !== e.aluop) begin n_fail++; $display("FAIL rnd_aluop inst=%h ri=%b aluop=%h exp=%b,%h", inst, ds_ri, ds_aluop, e.ri, e.aluop); end
            n_checks++; if (ds_rf_we !== e.we || ds_ov_en !== e.ov) begin n_fail++; $display("FAIL rnd_we_ov inst=%h we=%b ov=%b exp=%b,%b", inst, ds_rf_we, ds_ov_en, e.we, e.ov); end
            if (!e.ri) begin
                n_checks++; if (ds_scr1 !== e.scr1 || ds_rf_dest !== e.dest) begin n_fail++; $display("FAIL rnd_scr1_dest inst=%h scr1=%h dest=%0d exp=%h,%0d", inst, ds_scr1, ds_rf_dest, e.scr1, e.dest); end
                if (e.chk_scr0) begin
                    n_checks++; if (ds_scr0 !== e.scr0) begin n_fail++; $display("FAIL rnd_scr0 inst=%h got=%h exp=%h", inst, ds_scr0, e.scr0); end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_addiu();
        test_shift();
        test_lui_ori();
        test_hazard();
        test_backpressure();
        test_flush();
        test_ri();
        test_reset_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
